// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module : icache_pkg
//  Brief  : Shared FSM state type and geometry helpers for the icache block.
//  Rev    : 1.0
// ============================================================================
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PASS = 2'd2
    } state_t;

    localparam int C_DEFAULT_LINES = 64;
    localparam int C_ADDR_W        = 32;
    localparam int C_WORD_OFFSET   = 2;

    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int lines);
        return C_ADDR_W - C_WORD_OFFSET - $clog2(lines);
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
//  Module : icache_array
//  Brief  : Direct-mapped valid/tag/data storage, async read, sync write,
//           single-cycle bulk invalidate.
//  Rev    : 1.0
// ============================================================================
module icache_array #(
    parameter int LINES = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_index,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [31:0]      o_rd_data,
    input  logic             i_wr_en,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_data,
    input  logic             i_inval_en,
    input  logic             i_clear_all
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    assign o_rd_valid = r_valid[i_index];
    assign o_rd_tag   = r_tag[i_index];
    assign o_rd_data  = r_data[i_index];

    // Bulk clear wins over a same-cycle install so a flush is never undone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_clear_all) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_index] <= 1'b1;
        end else if (i_inval_en) begin
            r_valid[i_index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_index]  <= i_wr_tag;
            r_data[i_index] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module : icache
//  Brief  : Direct-mapped one-word-line instruction cache with write-through
//           pass-thru path, flush and hit/miss counters.
//  Rev    : 1.0
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int LINES = C_DEFAULT_LINES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_valid,
    input  logic        ext_instruction,
    output logic        ext_ready,
    input  logic [31:0] ext_address,
    input  logic [31:0] ext_write_data,
    input  logic [3:0]  ext_write_strobe,
    output logic [31:0] ext_read_data,
    output logic        mem_valid,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_strobe,
    input  logic        mem_ready,
    input  logic [31:0] mem_read_data,
    input  logic        flush,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int c_IDX_W = index_width(LINES);
    localparam int c_TAG_W = tag_width(LINES);

    state_t r_state;
    state_t w_state_next;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_strobe;
    logic        r_flush_seen;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    logic [31:0]        w_lookup_addr;
    logic [c_IDX_W-1:0] w_index;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_line_valid;
    logic [c_TAG_W-1:0] w_line_tag;
    logic [31:0]        w_line_data;
    logic               w_line_match;
    logic               w_is_fetch;
    logic               w_req;
    logic               w_hit;
    logic               w_miss;
    logic               w_mem_done;
    logic               w_install;
    logic               w_inval;
    logic               w_unused_offset;

    // While a transfer is outstanding the array is addressed by the latched request.
    assign w_lookup_addr   = (r_state == ST_IDLE) ? ext_address : r_addr;
    assign w_index         = w_lookup_addr[C_WORD_OFFSET +: c_IDX_W];
    assign w_tag           = w_lookup_addr[C_ADDR_W-1 -: c_TAG_W];
    assign w_unused_offset = ^w_lookup_addr[C_WORD_OFFSET-1:0];

    assign w_line_match = w_line_valid && (w_line_tag == w_tag);
    assign w_is_fetch   = ext_instruction && (ext_write_strobe == 4'd0);
    assign w_req        = (r_state == ST_IDLE) && ext_valid && !reset;
    assign w_hit        = w_req && w_is_fetch && w_line_match;
    assign w_miss       = w_req && w_is_fetch && !w_line_match;
    assign w_mem_done   = (r_state != ST_IDLE) && mem_ready && !reset;
    assign w_install    = (r_state == ST_FILL) && w_mem_done && !r_flush_seen && !flush;
    assign w_inval      = (r_state == ST_PASS) && w_mem_done && (r_strobe != 4'd0) && w_line_match;

    icache_array #(
        .LINES (LINES),
        .IDX_W (c_IDX_W),
        .TAG_W (c_TAG_W)
    ) u_array (
        .clk         (clk),
        .rst         (reset),
        .i_index     (w_index),
        .o_rd_valid  (w_line_valid),
        .o_rd_tag    (w_line_tag),
        .o_rd_data   (w_line_data),
        .i_wr_en     (w_install),
        .i_wr_tag    (w_tag),
        .i_wr_data   (mem_read_data),
        .i_inval_en  (w_inval),
        .i_clear_all (flush)
    );

    always_comb begin
        w_state_next     = r_state;
        ext_ready        = 1'b0;
        ext_read_data    = w_line_data;
        mem_valid        = 1'b0;
        mem_write_strobe = 4'd0;
        case (r_state)
            ST_IDLE: begin
                ext_ready = w_hit;
                if (w_miss) begin
                    w_state_next = ST_FILL;
                end else if (w_req && !w_is_fetch) begin
                    w_state_next = ST_PASS;
                end
            end
            ST_FILL, ST_PASS: begin
                mem_valid        = !reset;
                mem_write_strobe = (r_state == ST_PASS && !reset) ? r_strobe : 4'd0;
                ext_ready        = w_mem_done && ext_valid;
                ext_read_data    = mem_read_data;
                if (w_mem_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign mem_address    = r_addr;
    assign mem_write_data = r_wdata;
    assign hit_count      = r_hit_count;
    assign miss_count     = r_miss_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_strobe     <= 4'd0;
            r_flush_seen <= 1'b0;
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_req && !w_hit) begin
                r_addr       <= ext_address;
                r_wdata      <= ext_write_data;
                r_strobe     <= ext_write_strobe;
                r_flush_seen <= 1'b0;
            end else if (flush && r_state == ST_FILL) begin
                r_flush_seen <= 1'b1;
            end
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module : tb_icache
//  Brief  : Directed self-checking bench for icache with a scripted memory.
//  Rev    : 1.0
// ============================================================================
module tb_icache;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ext_valid = 1'b0;
    logic        ext_instruction = 1'b0;
    logic        ext_ready;
    logic [31:0] ext_address = 32'd0;
    logic [31:0] ext_write_data = 32'd0;
    logic [3:0]  ext_write_strobe = 4'd0;
    logic [31:0] ext_read_data;
    logic        mem_valid;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_strobe;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_read_data = 32'd0;
    logic        flush = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache #(.LINES(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .ext_valid        (ext_valid),
        .ext_instruction  (ext_instruction),
        .ext_ready        (ext_ready),
        .ext_address      (ext_address),
        .ext_write_data   (ext_write_data),
        .ext_write_strobe (ext_write_strobe),
        .ext_read_data    (ext_read_data),
        .mem_valid        (mem_valid),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_strobe (mem_write_strobe),
        .mem_ready        (mem_ready),
        .mem_read_data    (mem_read_data),
        .flush            (flush),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [31:0] addr, input logic instr,
                             input logic [3:0] strb, input logic [31:0] wdata);
        @(negedge clk);
        ext_valid        = 1'b1;
        ext_instruction  = instr;
        ext_address      = addr;
        ext_write_strobe = strb;
        ext_write_data   = wdata;
        #1;
    endtask

    task automatic end_req();
        @(posedge clk);
        #1;
        ext_valid        = 1'b0;
        ext_write_strobe = 4'd0;
        mem_ready        = 1'b0;
    endtask

    // Request that must go to memory; memory answers after `waits` busy cycles.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic instr,
                        input logic [3:0] strb, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input int flush_at);
        start_req(addr, instr, strb, wdata);
        chk({tag, "_idle_ready"}, {31'd0, ext_ready}, 32'd0);
        chk({tag, "_idle_memvalid"}, {31'd0, mem_valid}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            flush = (i == flush_at);
            #1;
            chk({tag, "_memvalid"}, {31'd0, mem_valid}, 32'd1);
            chk({tag, "_memaddr"}, mem_address, addr);
            chk({tag, "_memstrobe"}, {28'd0, mem_write_strobe}, (instr && strb == 4'd0) ? 32'd0 : {28'd0, strb});
            chk({tag, "_busy_ready"}, {31'd0, ext_ready}, 32'd0);
        end
        if (strb != 4'd0) chk({tag, "_memwdata"}, mem_write_data, wdata);
        @(negedge clk);
        flush         = 1'b0;
        mem_ready     = 1'b1;
        mem_read_data = rdata;
        #1;
        chk({tag, "_done_ready"}, {31'd0, ext_ready}, 32'd1);
        chk({tag, "_done_data"}, ext_read_data, rdata);
        end_req();
    endtask

    task automatic hit(input string tag, input logic [31:0] addr, input logic [31:0] exp_data);
        start_req(addr, 1'b1, 4'd0, 32'd0);
        chk({tag, "_ready"}, {31'd0, ext_ready}, 32'd1);
        chk({tag, "_data"}, ext_read_data, exp_data);
        chk({tag, "_memvalid"}, {31'd0, mem_valid}, 32'd0);
        end_req();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {31'd0, ext_ready}, 32'd0);
        chk("rst_memvalid", {31'd0, mem_valid}, 32'd0);
        chk("rst_strobe", {28'd0, mem_write_strobe}, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Cold fetch miss, 3 cycles of mem_valid
        xfer("miss100", 32'h100, 1'b1, 4'd0, 32'd0, 32'h0000_0013, 2, -1);
        chk("miss100_count", miss_count, 32'd1);
        chk("miss100_hits", hit_count, 32'd0);

        // Hit, then two back-to-back hits
        hit("hit100", 32'h100, 32'h0000_0013);
        chk("hit100_count", hit_count, 32'd1);
        start_req(32'h100, 1'b1, 4'd0, 32'd0);
        chk("b2b_first", {31'd0, ext_ready}, 32'd1);
        @(negedge clk);
        #1;
        chk("b2b_second", {31'd0, ext_ready}, 32'd1);
        chk("b2b_data", ext_read_data, 32'h0000_0013);
        end_req();
        chk("b2b_hits", hit_count, 32'd3);

        // Store invalidates the matching line
        xfer("st100", 32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 1, -1);
        chk("st100_misses", miss_count, 32'd1);
        chk("st100_hits", hit_count, 32'd3);
        xfer("refetch100", 32'h100, 1'b1, 4'd0, 32'd0, 32'hDEAD_BEEF, 1, -1);
        chk("refetch100_count", miss_count, 32'd2);
        hit("hit100b", 32'h100, 32'hDEAD_BEEF);

        // Idle flush then conflicting tags at index 0
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        xfer("conf100a", 32'h100, 1'b1, 4'd0, 32'd0, 32'h1111_1111, 1, -1);
        xfer("conf200", 32'h200, 1'b1, 4'd0, 32'd0, 32'h2222_2222, 1, -1);
        xfer("conf100b", 32'h100, 1'b1, 4'd0, 32'd0, 32'h1111_1111, 1, -1);
        chk("conf_misses", miss_count, 32'd5);
        chk("conf_hits", hit_count, 32'd4);

        // Flush during a fill: data returned, nothing installed
        xfer("flfill104", 32'h104, 1'b1, 4'd0, 32'd0, 32'h5555_AAAA, 3, 1);
        xfer("after_fl100", 32'h100, 1'b1, 4'd0, 32'd0, 32'h1111_1111, 1, -1);
        xfer("after_fl104", 32'h104, 1'b1, 4'd0, 32'd0, 32'h5555_AAAA, 1, -1);
        chk("flfill_misses", miss_count, 32'd8);
        hit("hit104", 32'h104, 32'h5555_AAAA);

        // Hit in the flush cycle is served from pre-flush contents
        start_req(32'h104, 1'b1, 4'd0, 32'd0);
        flush = 1'b1;
        #1;
        chk("flhit_ready", {31'd0, ext_ready}, 32'd1);
        chk("flhit_data", ext_read_data, 32'h5555_AAAA);
        end_req();
        flush = 1'b0;
        chk("flhit_hits", hit_count, 32'd6);
        xfer("after_flhit104", 32'h104, 1'b1, 4'd0, 32'd0, 32'h5555_AAAA, 1, -1);
        chk("flhit_misses", miss_count, 32'd9);

        // Write to same index, different tag leaves the line alone
        xfer("st204", 32'h204, 1'b0, 4'h3, 32'hCAFE_0000, 32'h0, 1, -1);
        hit("hit104_kept", 32'h104, 32'h5555_AAAA);
        xfer("st104", 32'h104, 1'b0, 4'h1, 32'h0000_00AA, 32'h0, 1, -1);
        xfer("miss104_inval", 32'h104, 1'b1, 4'd0, 32'd0, 32'h5555_AAAA, 1, -1);
        chk("inval_misses", miss_count, 32'd10);
        chk("inval_hits", hit_count, 32'd7);

        // Reset in the middle of a data-read pass
        start_req(32'h108, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        #1;
        chk("rdpass_memvalid", {31'd0, mem_valid}, 32'd1);
        @(negedge clk);
        reset         = 1'b1;
        mem_ready     = 1'b1;
        mem_read_data = 32'hBAD0_BAD0;
        #1;
        chk("rstpass_ready", {31'd0, ext_ready}, 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b0;
        ext_valid = 1'b0;
        #1;
        chk("rstpass_memvalid", {31'd0, mem_valid}, 32'd0);
        chk("rstpass_ready2", {31'd0, ext_ready}, 32'd0);
        chk("rstpass_misses", miss_count, 32'd0);
        xfer("post_rst104", 32'h104, 1'b1, 4'd0, 32'd0, 32'h7777_0000, 1, -1);
        chk("post_rst_misses", miss_count, 32'd1);

        // Stray mem_ready in idle is ignored
        @(negedge clk);
        mem_ready     = 1'b1;
        mem_read_data = 32'h0BAD_F00D;
        #1;
        chk("stray_ready", {31'd0, ext_ready}, 32'd0);
        chk("stray_memvalid", {31'd0, mem_valid}, 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        hit("post_stray_hit", 32'h104, 32'h7777_0000);
        chk("final_hits", hit_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
